// File: rtl/lane_arbiter.sv
// Round-robin arbiter for one unidirectional interposer lane.
// It picks one legal requester, runs that node's tenure through
// GRANT -> XFER (XFER_CYCLES) -> RELEASE, and drives every node's
// send/receive/busy control bits. All outputs are registered.
module lane_arbiter #(
    parameter int NODE_COUNT       = 8,
    parameter int NODE_COUNT_DIGIT = 3,
    parameter int REQ_W            = NODE_COUNT_DIGIT + 1,
    parameter int CTRL_W           = 3,
    parameter int DIRECTION        = 0,
    parameter int XFER_CYCLES      = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NODE_COUNT*REQ_W-1:0]        req_in,
    output logic [NODE_COUNT*CTRL_W-1:0]       ctrl_out,
    output logic                               grant_valid,
    output logic [NODE_COUNT_DIGIT-1:0]        grant_src,
    output logic [NODE_COUNT_DIGIT-1:0]        grant_dst,
    output logic                               err_illegal
);

    localparam int CNT_W = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XFER_CYCLES - 1);
    localparam logic [NODE_COUNT_DIGIT-1:0] PTR_INIT = NODE_COUNT_DIGIT'(NODE_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_XFER,
        S_RELEASE
    } state_t;

    state_t                                   r_state;
    logic [NODE_COUNT_DIGIT-1:0]              r_rr_ptr;
    logic [NODE_COUNT_DIGIT-1:0]              r_src;
    logic [NODE_COUNT_DIGIT-1:0]              r_dst;
    logic [CNT_W-1:0]                         r_xfer_cnt;
    logic [NODE_COUNT-1:0][CTRL_W-1:0]        r_ctrl;
    logic                                     r_grant_valid;
    logic                                     r_err;

    logic [NODE_COUNT_DIGIT-1:0]              w_dest [NODE_COUNT];
    logic [NODE_COUNT-1:0]                    w_elig;
    logic [NODE_COUNT-1:0]                    w_illeg;
    logic                                     w_hit;
    logic [NODE_COUNT_DIGIT-1:0]              w_win;
    logic [NODE_COUNT_DIGIT-1:0]              w_idx;
    logic [NODE_COUNT-1:0][CTRL_W-1:0]        w_ctrl_send;
    logic [NODE_COUNT-1:0][CTRL_W-1:0]        w_ctrl_rx;

    // Per-node request decode: a request is legal only if its destination
    // lies strictly on this lane's side of the requester (which also rules
    // out dest == self).
    for (genvar g = 0; g < NODE_COUNT; g++) begin : g_node
        localparam logic [NODE_COUNT_DIGIT-1:0] ID = NODE_COUNT_DIGIT'(g);
        logic w_vld;
        logic w_side;
        assign w_dest[g]  = req_in[g*REQ_W +: NODE_COUNT_DIGIT];
        assign w_vld      = req_in[g*REQ_W + REQ_W - 1];
        assign w_side     = (DIRECTION == 0) ? (w_dest[g] > ID) : (w_dest[g] < ID);
        assign w_elig[g]  = w_vld & w_side;
        assign w_illeg[g] = w_vld & ~w_side;
    end

    // Round-robin scan starting just after the last owner, wrapping modulo NODE_COUNT.
    always_comb begin
        w_hit = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = 1; k <= NODE_COUNT; k++) begin
            w_idx = NODE_COUNT_DIGIT'((int'(r_rr_ptr) + k) % NODE_COUNT);
            if (!w_hit && w_elig[w_idx]) begin
                w_hit = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Control patterns for the GRANT cycle (send only) and XFER cycles (send + receive).
    always_comb begin
        w_ctrl_send              = {NODE_COUNT{CTRL_W'(1)}};
        w_ctrl_send[w_win][2]    = 1'b1;
        w_ctrl_rx                = {NODE_COUNT{CTRL_W'(1)}};
        w_ctrl_rx[r_src][2]      = 1'b1;
        w_ctrl_rx[r_dst][1]      = 1'b1;
    end

    // Tenure sequencer with registered outputs; reset aborts any tenure at once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= PTR_INIT;
            r_src         <= '0;
            r_dst         <= '0;
            r_xfer_cnt    <= '0;
            r_ctrl        <= '0;
            r_grant_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_err <= |w_illeg;
                    if (w_hit) begin
                        r_state       <= S_GRANT;
                        r_src         <= w_win;
                        r_dst         <= w_dest[w_win];
                        r_ctrl        <= w_ctrl_send;
                        r_grant_valid <= 1'b1;
                    end
                end
                S_GRANT: begin
                    r_state    <= S_XFER;
                    r_xfer_cnt <= '0;
                    r_ctrl     <= w_ctrl_rx;
                end
                S_XFER: begin
                    if (r_xfer_cnt == CNT_LAST) begin
                        r_state       <= S_RELEASE;
                        r_ctrl        <= '0;
                        r_grant_valid <= 1'b0;
                        r_rr_ptr      <= r_src;
                    end else begin
                        r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ctrl_out    = r_ctrl;
    assign grant_valid = r_grant_valid;
    assign grant_src   = r_src;
    assign grant_dst   = r_dst;
    assign err_illegal = r_err;

endmodule

// File: tb/tb_lane_arbiter.sv
// Directed bench for lane_arbiter. Three instances cover the upward lane
// with single-cycle transfers (A), the downward lane (B) and the upward
// lane with three-cycle transfers (C). Expected outputs are queued as
// each step is driven and compared after the following clock edge.
module tb_lane_arbiter;

    logic clk;
    logic rst_a, rst_b, rst_c;
    logic [31:0] req_a, req_b, req_c;
    logic [23:0] ctrl_a, ctrl_b, ctrl_c;
    logic gv_a, gv_b, gv_c;
    logic [2:0] src_a, src_b, src_c;
    logic [2:0] dst_a, dst_b, dst_c;
    logic err_a, err_b, err_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        int         u;
        logic [23:0] c;
        logic       gv;
        logic [2:0] s;
        logic [2:0] d;
        logic       e;
        bit         sd;
    } exp_t;

    exp_t q[$];

    lane_arbiter #(.DIRECTION(0), .XFER_CYCLES(1)) u_a (
        .clk(clk), .reset(rst_a), .req_in(req_a), .ctrl_out(ctrl_a),
        .grant_valid(gv_a), .grant_src(src_a), .grant_dst(dst_a), .err_illegal(err_a));

    lane_arbiter #(.DIRECTION(1), .XFER_CYCLES(1)) u_b (
        .clk(clk), .reset(rst_b), .req_in(req_b), .ctrl_out(ctrl_b),
        .grant_valid(gv_b), .grant_src(src_b), .grant_dst(dst_b), .err_illegal(err_b));

    lane_arbiter #(.DIRECTION(0), .XFER_CYCLES(3)) u_c (
        .clk(clk), .reset(rst_c), .req_in(req_c), .ctrl_out(ctrl_c),
        .grant_valid(gv_c), .grant_src(src_c), .grant_dst(dst_c), .err_illegal(err_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request vector: add node n requesting destination d.
    function automatic logic [31:0] rq(input logic [31:0] b, input int n, input int d);
        return b | (32'(8 + d) << (n * 4));
    endfunction

    // Control vector: busy on all nodes, send on s, receive on d when rx.
    function automatic logic [23:0] cv(input int s, input int d, input bit rx);
        logic [23:0] v;
        v = {8{3'b001}};
        v = v | (24'(4) << (s * 3));
        if (rx) v = v | (24'(2) << (d * 3));
        return v;
    endfunction

    task automatic chk(input string tag, input string f, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed %0h expected %0h", tag, f, obs, exp);
        end
    endtask

    task automatic push(input int u, input string tag, input logic [23:0] c, input logic gv,
                        input int s, input int d, input logic e, input bit sd);
        exp_t x;
        x.tag = tag; x.u = u; x.c = c; x.gv = gv;
        x.s = 3'(s); x.d = 3'(d); x.e = e; x.sd = sd;
        q.push_back(x);
    endtask

    task automatic tick();
        exp_t x;
        logic [23:0] oc;
        logic og, oe;
        logic [2:0] os, od;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            x = q.pop_front();
            case (x.u)
                0:       begin oc = ctrl_a; og = gv_a; os = src_a; od = dst_a; oe = err_a; end
                1:       begin oc = ctrl_b; og = gv_b; os = src_b; od = dst_b; oe = err_b; end
                default: begin oc = ctrl_c; og = gv_c; os = src_c; od = dst_c; oe = err_c; end
            endcase
            chk(x.tag, "ctrl", 32'(oc), 32'(x.c));
            chk(x.tag, "gv",   32'(og), 32'(x.gv));
            chk(x.tag, "err",  32'(oe), 32'(x.e));
            if (x.sd) begin
                chk(x.tag, "src", 32'(os), 32'(x.s));
                chk(x.tag, "dst", 32'(od), 32'(x.d));
            end
        end
    endtask

    task automatic st(input int u, input string tag, input logic [23:0] c, input logic gv,
                      input int s, input int d, input logic e, input bit sd);
        push(u, tag, c, gv, s, d, e, sd);
        tick();
    endtask

    int ord [6] = '{3, 6, 1, 3, 6, 1};
    int dmap [8] = '{0, 4, 0, 7, 0, 0, 7, 0};

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF; req_c = 32'hFFFF_FFFF;

        // Reset held with every node requesting
        for (int r = 0; r < 2; r++) begin
            push(0, "rst_a", 24'h0, 1'b0, 0, 0, 1'b0, 1'b1);
            push(1, "rst_b", 24'h0, 1'b0, 0, 0, 1'b0, 1'b1);
            push(2, "rst_c", 24'h0, 1'b0, 0, 0, 1'b0, 1'b1);
            tick();
        end

        // First grant after reset goes to node 0; node 7 -> 7 flags illegal
        rst_a = 1'b1;
        st(0, "first_grant", cv(0, 7, 0), 1'b1, 0, 7, 1'b1, 1'b1);
        req_a = 32'h0;
        st(0, "first_xfer",  cv(0, 7, 1), 1'b1, 0, 7, 1'b0, 1'b1);
        st(0, "first_rel",   24'h0,       1'b0, 0, 7, 1'b0, 1'b1);
        st(0, "first_idle",  24'h0,       1'b0, 0, 7, 1'b0, 1'b1);

        // Single request 2 -> 5
        req_a = rq(32'h0, 2, 5);
        st(0, "single_grant", cv(2, 5, 0), 1'b1, 2, 5, 1'b0, 1'b1);
        req_a = 32'h0;
        st(0, "single_xfer",  cv(2, 5, 1), 1'b1, 2, 5, 1'b0, 1'b1);
        st(0, "single_rel",   24'h0,       1'b0, 2, 5, 1'b0, 1'b1);
        st(0, "single_idle",  24'h0,       1'b0, 2, 5, 1'b0, 1'b1);

        // Round robin among 1, 3, 6 (last owner was 2, so 3 goes first)
        req_a = rq(rq(rq(32'h0, 1, 4), 3, 7), 6, 7);
        for (int g = 0; g < 6; g++) begin
            st(0, "rr_grant", cv(ord[g], dmap[ord[g]], 0), 1'b1, ord[g], dmap[ord[g]], 1'b0, 1'b1);
            if (g == 5) req_a = 32'h0;
            st(0, "rr_xfer",  cv(ord[g], dmap[ord[g]], 1), 1'b1, ord[g], dmap[ord[g]], 1'b0, 1'b1);
            st(0, "rr_rel",   24'h0, 1'b0, ord[g], dmap[ord[g]], 1'b0, 1'b1);
            st(0, "rr_idle",  24'h0, 1'b0, ord[g], dmap[ord[g]], 1'b0, 1'b1);
        end

        // Illegal requests on the upward lane
        req_a = rq(32'h0, 5, 2);
        st(0, "ill_down", 24'h0, 1'b0, 1, 4, 1'b1, 1'b1);
        req_a = rq(32'h0, 4, 4);
        st(0, "ill_self", 24'h0, 1'b0, 1, 4, 1'b1, 1'b1);
        req_a = 32'h0;
        st(0, "ill_clear", 24'h0, 1'b0, 1, 4, 1'b0, 1'b1);
        st(0, "ill_idle",  24'h0, 1'b0, 1, 4, 1'b0, 1'b1);

        // Downward lane: 5 -> 2 is legal
        req_b = rq(32'h0, 5, 2);
        rst_b = 1'b1;
        st(1, "dn_grant", cv(5, 2, 0), 1'b1, 5, 2, 1'b0, 1'b1);
        req_b = 32'h0;
        st(1, "dn_xfer",  cv(5, 2, 1), 1'b1, 5, 2, 1'b0, 1'b1);
        st(1, "dn_rel",   24'h0, 1'b0, 5, 2, 1'b0, 1'b1);
        st(1, "dn_idle",  24'h0, 1'b0, 5, 2, 1'b0, 1'b1);

        // Move the pointer to 6
        req_b = rq(32'h0, 6, 1);
        st(1, "p6_grant", cv(6, 1, 0), 1'b1, 6, 1, 1'b0, 1'b1);
        req_b = 32'h0;
        st(1, "p6_xfer",  cv(6, 1, 1), 1'b1, 6, 1, 1'b0, 1'b1);
        st(1, "p6_rel",   24'h0, 1'b0, 6, 1, 1'b0, 1'b1);
        st(1, "p6_idle",  24'h0, 1'b0, 6, 1, 1'b0, 1'b1);

        // Wrap-around: 7 -> 3 wins, 0 -> 5 is illegal downward
        req_b = rq(rq(32'h0, 7, 3), 0, 5);
        st(1, "wrap_grant", cv(7, 3, 0), 1'b1, 7, 3, 1'b1, 1'b1);
        req_b = rq(32'h0, 0, 5);
        st(1, "wrap_xfer",  cv(7, 3, 1), 1'b1, 7, 3, 1'b0, 1'b1);
        st(1, "wrap_rel",   24'h0, 1'b0, 7, 3, 1'b0, 1'b1);
        st(1, "wrap_idle",  24'h0, 1'b0, 7, 3, 1'b0, 1'b1);
        st(1, "wrap_ill0",  24'h0, 1'b0, 7, 3, 1'b1, 1'b1);
        req_b = 32'h0;
        st(1, "wrap_clear", 24'h0, 1'b0, 7, 3, 1'b0, 1'b1);

        // Three-cycle transfer; request dropped during the tenure
        req_c = rq(32'h0, 0, 7);
        rst_c = 1'b1;
        st(2, "x3_grant", cv(0, 7, 0), 1'b1, 0, 7, 1'b0, 1'b1);
        req_c = 32'h0;
        for (int k = 0; k < 3; k++)
            st(2, "x3_xfer", cv(0, 7, 1), 1'b1, 0, 7, 1'b0, 1'b1);
        st(2, "x3_rel",   24'h0, 1'b0, 0, 7, 1'b0, 1'b1);
        st(2, "x3_idle",  24'h0, 1'b0, 0, 7, 1'b0, 1'b1);

        // Reset in the second XFER cycle aborts the tenure
        req_c = rq(32'h0, 3, 6);
        st(2, "ab_grant", cv(3, 6, 0), 1'b1, 3, 6, 1'b0, 1'b1);
        req_c = 32'h0;
        st(2, "ab_xfer1", cv(3, 6, 1), 1'b1, 3, 6, 1'b0, 1'b1);
        st(2, "ab_xfer2", cv(3, 6, 1), 1'b1, 3, 6, 1'b0, 1'b1);
        rst_c = 1'b0;
        st(2, "ab_reset", 24'h0, 1'b0, 0, 0, 1'b0, 1'b1);
        rst_c = 1'b1;
        req_c = rq(rq(rq(32'h0, 3, 6), 0, 7), 5, 6);
        st(2, "ab_regrant", cv(0, 7, 0), 1'b1, 0, 7, 1'b0, 1'b1);
        req_c = 32'h0;
        for (int k = 0; k < 3; k++)
            st(2, "ab_xfer", cv(0, 7, 1), 1'b1, 0, 7, 1'b0, 1'b1);
        st(2, "ab_rel",  24'h0, 1'b0, 0, 7, 1'b0, 1'b1);
        st(2, "ab_idle", 24'h0, 1'b0, 0, 7, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_arbiter.md
Name: lane_arbiter

Overview:
Centralised arbiter for one unidirectional interposer lane shared by all NODE_COUNT nodes. Each node's NodeIO raises a request carrying the destination ID. The arbiter selects one legal requester round-robin, sequences that node's tenure on the lane, and drives each node's per-lane control field. One instance serves the low-to-high lane (DIRECTION=0) and one serves the high-to-low lane (DIRECTION=1).

Parameters:
NODE_COUNT, 8, number of nodes on the lane
NODE_COUNT_DIGIT, 3, node ID width (log2 NODE_COUNT)
REQ_W, NODE_COUNT_DIGIT+1, per-node request field width
CTRL_W, 3, per-node control field width
DIRECTION, 0, 0: legal only if dest>src; 1: legal only if dest<src
XFER_CYCLES, 1, cycles the lane is held per tenure (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_in  in  NODE_COUNT*REQ_W  node i at [i*REQ_W +: REQ_W]; MSB = request valid, low NODE_COUNT_DIGIT bits = destination ID
ctrl_out  out  NODE_COUNT*CTRL_W  node i at [i*CTRL_W +: CTRL_W]; bit2 = send (drive lane), bit1 = receive (latch lane), bit0 = lane busy
grant_valid  out  1  a tenure is in GRANT or XFER
grant_src  out  NODE_COUNT_DIGIT  current owner ID
grant_dst  out  NODE_COUNT_DIGIT  current destination ID
err_illegal  out  1  one-cycle pulse: an illegal request was seen while IDLE

Behaviour:
- All outputs are registered. On reset low at a clk edge: ctrl_out=0, grant_valid=0, grant_src=0, grant_dst=0, err_illegal=0, state=IDLE, rr_ptr=NODE_COUNT-1, xfer_cnt=0. Reset mid-tenure aborts it immediately with no RELEASE cycle.
- Eligibility of node i: valid=1, dest!=i, and dest on the correct side of i per DIRECTION. If an ineligible valid request is present while IDLE, err_illegal pulses for 1 cycle and that request is never granted.
- State IDLE: scan eligible nodes starting at (rr_ptr+1) mod NODE_COUNT, wrapping around. First hit W: latch grant_src=W and grant_dst=dest(W), go to GRANT. No hit: stay in IDLE.
- State GRANT (1 cycle): ctrl[W].send=1, busy=1 for all nodes, grant_valid=1. Go to XFER with xfer_cnt=0.
- State XFER: ctrl[W].send=1, ctrl[dst].receive=1, busy=1 for all nodes. xfer_cnt increments. Exit to RELEASE when xfer_cnt==XFER_CYCLES-1, so XFER lasts exactly XFER_CYCLES cycles.
- State RELEASE (1 cycle): ctrl_out=0, grant_valid=0, rr_ptr<=W. Go to IDLE.
- Latency: request present before edge E0 in IDLE -> send visible after E0 -> receive visible after E1. Minimum spacing between successive grants is XFER_CYCLES+3 cycles.
- The destination is sampled only in IDLE. Request drop or destination change during GRANT/XFER is ignored and the tenure completes.
- A node still requesting after its tenure competes again, but its priority is lowest next round (rr_ptr=W).
- Arithmetic: rr_ptr and the scan index wrap modulo NODE_COUNT. xfer_cnt is wide enough for XFER_CYCLES-1.
- Only one send and at most one receive bit are set at any time. No other ctrl bits toggle.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all nodes requesting -> ctrl_out=0, grant_valid=0. Release reset; first grant goes to node 0 (rr_ptr=7) if node 0 is eligible.
- Single request, DIRECTION=0, XFER_CYCLES=1: node 2 requests dest 5 -> ctrl[2]=3'b101 after E0, ctrl[2]=3'b101 and ctrl[5]=3'b011 after E1, all zero after E2, grant_src=2, grant_dst=5.
- Round robin: nodes 1, 3 and 6 all request upward continuously -> grant order 1,3,6,1,3,6, with grants spaced 4 cycles apart when XFER_CYCLES=1.
- Illegal request, DIRECTION=0: node 5 requests dest 2, then node 4 requests dest 4 -> err_illegal pulses, no grant, state stays IDLE. With DIRECTION=1, node 5 -> dest 2 is granted.
- Mid-tenure changes, XFER_CYCLES=3: node 0 -> dest 7 granted; drop the request during XFER -> XFER still lasts 3 cycles. Assert reset during XFER cycle 2 -> all outputs 0 on the next edge, then node 0 has priority again after reset.
- Wrap-around: rr_ptr=6, nodes 7 and 0 request with DIRECTION=1 (node 7 -> dest 3) -> node 7 is granted first, then node 0 only if its request is legal; otherwise err_illegal.
